// File: rtl/scaler_window_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | scaler_window_ctrl : raster walker that fetches the 3x3 neighbourhood of   |
// | each pixel, presents the 8 taps to image_scalar and streams out its Tpix.  |
// | Optional macro BORDER_ZERO_EN: zero-fill out-of-image taps on the border.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module scaler_window_ctrl #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int ADDR_W = 16,
    parameter int LAT    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        T1,
    output logic [7:0]        T2,
    output logic [7:0]        T3,
    output logic [7:0]        T4,
    output logic [7:0]        B1,
    output logic [7:0]        B2,
    output logic [7:0]        B3,
    output logic [7:0]        B4,
    input  logic [7:0]        Tpix,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last
);
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [ADDR_W-1:0] c_w        = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] c_one      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [COL_W-1:0]  c_col_max  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  c_row_max  = ROW_W'(IMG_H - 1);
    localparam logic [7:0]        c_wait_init = 8'(LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_idx;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [7:0]        r_pend;
    logic              r_first;
    logic [7:0]        r_wait;
    logic              r_cap_vld, r_cap_first, r_cap_all;
    logic [2:0]        r_cap_slot;
    logic [7:0]        r_tap [8];

    logic              w_top_ok, w_bot_ok, w_left_ok, w_right_ok, w_replicate;
    logic [7:0]        w_ok, w_todo, w_slot_oh;
    logic [2:0]        w_slot;
    logic              w_fetch_last, w_last_pix;
    logic [ADDR_W-1:0] w_addr;

    assign w_top_ok   = (r_row != '0);
    assign w_bot_ok   = (r_row != c_row_max);
    assign w_left_ok  = (r_col != '0);
    assign w_right_ok = (r_col != c_col_max);
    assign w_last_pix = (r_idx == c_last_idx);

    // Slot order matches tap order TL,T,TR,L,R,BL,B,BR.
`ifdef BORDER_ZERO_EN
    assign w_ok = {w_bot_ok & w_right_ok, w_bot_ok, w_bot_ok & w_left_ok, w_right_ok,
                   w_left_ok, w_top_ok & w_right_ok, w_top_ok, w_top_ok & w_left_ok};
    assign w_replicate = 1'b0;
`else
    logic w_border;
    assign w_border    = !(w_top_ok && w_bot_ok && w_left_ok && w_right_ok);
    assign w_ok        = w_border ? 8'h01 : 8'hFF;
    assign w_replicate = w_border;
`endif

    // Next read is the lowest slot still pending and inside the image.
    assign w_todo = r_pend & w_ok;
    always_comb begin
        w_slot = 3'd0;
        for (int j = 7; j >= 0; j--) begin
            if (w_todo[j]) w_slot = 3'(j);
        end
    end
    assign w_slot_oh    = 8'b1 << w_slot;
    assign w_fetch_last = ((w_todo & ~w_slot_oh) == 8'h00);

    always_comb begin
        w_addr = r_idx;
        if (!w_replicate) begin
            case (w_slot)
                3'd0:    w_addr = r_idx - c_w - c_one;
                3'd1:    w_addr = r_idx - c_w;
                3'd2:    w_addr = r_idx - c_w + c_one;
                3'd3:    w_addr = r_idx - c_one;
                3'd4:    w_addr = r_idx + c_one;
                3'd5:    w_addr = r_idx + c_w - c_one;
                3'd6:    w_addr = r_idx + c_w;
                default: w_addr = r_idx + c_w + c_one;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        busy      = 1'b1;
        done      = 1'b0;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_FETCH;
            end
            S_FETCH: begin
                mem_rd   = 1'b1;
                mem_addr = w_addr;
                if (w_fetch_last) w_next = S_LOAD;
            end
            S_LOAD: w_next = S_WAIT;
            S_WAIT: if (r_wait == 8'd0) w_next = S_OUT;
            S_OUT: begin
                out_valid = 1'b1;
                out_last  = w_last_pix;
                if (out_ready) w_next = w_last_pix ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_pend      <= '0;
            r_first     <= 1'b0;
            r_wait      <= '0;
            r_cap_vld   <= 1'b0;
            r_cap_first <= 1'b0;
            r_cap_all   <= 1'b0;
            r_cap_slot  <= '0;
            out_data    <= '0;
            for (int j = 0; j < 8; j++) r_tap[j] <= '0;
        end else begin
            r_cap_vld <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_idx   <= '0;
                    r_col   <= '0;
                    r_row   <= '0;
                    r_pend  <= 8'hFF;
                    r_first <= 1'b1;
                end
                S_FETCH: begin
                    r_pend      <= r_pend & ~w_slot_oh;
                    r_first     <= 1'b0;
                    r_cap_vld   <= 1'b1;
                    r_cap_slot  <= w_slot;
                    r_cap_first <= r_first;
                    r_cap_all   <= w_replicate;
                end
                S_LOAD: r_wait <= c_wait_init;
                S_WAIT: begin
                    if (r_wait == 8'd0) out_data <= Tpix;
                    else                r_wait   <= r_wait - 8'd1;
                end
                S_OUT: if (out_ready && !w_last_pix) begin
                    r_idx   <= r_idx + 1'b1;
                    r_pend  <= 8'hFF;
                    r_first <= 1'b1;
                    if (r_col == c_col_max) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                default: ;
            endcase
            // Read data lands one cycle after its strobe; the first capture of a
            // pixel also clears taps that have no read this pixel.
            if (r_cap_vld) begin
                for (int j = 0; j < 8; j++) begin
                    if (r_cap_all || (r_cap_slot == 3'(j))) r_tap[j] <= mem_rdata;
                    else if (r_cap_first && !w_ok[j])        r_tap[j] <= '0;
                end
            end
        end
    end

    assign T1 = r_tap[0];
    assign T2 = r_tap[1];
    assign T3 = r_tap[2];
    assign T4 = r_tap[3];
    assign B1 = r_tap[4];
    assign B2 = r_tap[5];
    assign B3 = r_tap[6];
    assign B4 = r_tap[7];

endmodule
`default_nettype wire

// File: tb/tb_scaler_window_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_scaler_window_ctrl : directed bench, 4x4 image with mem[k]=k, LAT=2.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_scaler_window_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        out_ready = 1'b1;
    logic [7:0]  mem_rdata = 8'd0;
    logic        busy, done, mem_rd, out_valid, out_last;
    logic [15:0] mem_addr;
    logic [7:0]  T1, T2, T3, T4, B1, B2, B3, B4, Tpix, out_data;
    logic [7:0]  mem [16];
    int          n_chk = 0;
    int          n_pass = 0;

    scaler_window_ctrl #(.IMG_W(4), .IMG_H(4), .ADDR_W(16), .LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .T1(T1), .T2(T2), .T3(T3), .T4(T4), .B1(B1), .B2(B2), .B3(B3), .B4(B4),
        .Tpix(Tpix), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Stand-in for image_scalar: position-weighted tap sum.
    assign Tpix = 8'(T1 + 2*T2 + 3*T3 + 4*T4 + 5*B1 + 6*B2 + 7*B3 + 8*B4);

    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr[3:0]];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [63:0] exp_taps(input int p);
        logic [63:0] t;
        int r, c;
        t = '0;
        r = p / 4;
        c = p % 4;
        for (int j = 0; j < 8; j++) begin
            int dr, dc, nr, nc;
            logic [7:0] v;
            dr = (j < 3) ? -1 : ((j < 5) ? 0 : 1);
            dc = (j == 0 || j == 3 || j == 5) ? -1 : ((j == 1 || j == 6) ? 0 : 1);
            nr = r + dr;
            nc = c + dc;
`ifdef BORDER_ZERO_EN
            v = (nr < 0 || nr > 3 || nc < 0 || nc > 3) ? 8'd0 : 8'(nr * 4 + nc);
`else
            v = (r == 0 || r == 3 || c == 0 || c == 3) ? 8'(p) : 8'(nr * 4 + nc);
`endif
            t[63-8*j -: 8] = v;
        end
        return t;
    endfunction

    function automatic logic [7:0] exp_data(input int p);
        logic [63:0] t;
        int s;
        t = exp_taps(p);
        s = 0;
        for (int j = 0; j < 8; j++) s += (j + 1) * int'(t[63-8*j -: 8]);
        return 8'(s);
    endfunction

    function automatic logic [63:0] taps();
        return {T1, T2, T3, T4, B1, B2, B3, B4};
    endfunction

    task automatic run_frame(input int stall_pix, input bit poke_start);
        int beats, dones, rd_cnt, first_rd, cyc, stall, resume_at;
        bit rd_in_stall, fin;
        logic [23:0] addr_log;
        beats = 0; dones = 0; rd_cnt = 0; first_rd = 0; cyc = 0; stall = 0;
        resume_at = -1; rd_in_stall = 0; fin = 0; addr_log = 24'hFFFFFF;
        start = 1'b1;
        while (!fin && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start = (poke_start && cyc == 30);
            if (cyc == resume_at) begin
`ifdef BORDER_ZERO_EN
                check("resume_rd", {mem_rd, mem_addr}, {1'b1, 16'(stall_pix + 1 - 5)});
`else
                check("resume_rd", {mem_rd, mem_addr}, {1'b1, 16'(stall_pix + 1)});
`endif
            end
            if (mem_rd) begin
                if (rd_cnt == 0) first_rd = cyc;
                rd_cnt++;
                if (beats == 0) addr_log = {addr_log[15:0], mem_addr[7:0]};
            end
            if (done) dones++;
            if (out_valid) begin
                if (beats == stall_pix && stall < 5) begin
                    out_ready = 1'b0;
                    stall++;
                    if (mem_rd) rd_in_stall = 1'b1;
                end else begin
                    out_ready = 1'b1;
                    check($sformatf("data_p%0d", beats), out_data, exp_data(beats));
                    check($sformatf("last_p%0d", beats), out_last, beats == 15);
                    if (beats == 0) begin
                        check("taps_p0", taps(), exp_taps(0));
`ifdef BORDER_ZERO_EN
                        check("rds_p0", rd_cnt, 3);
                        check("addrs_p0", addr_log, 24'h010405);
`else
                        check("rds_p0", rd_cnt, 1);
                        check("addrs_p0", addr_log[7:0], 8'h00);
`endif
                    end
                    if (beats == 5) begin
                        check("taps_p5", taps(), exp_taps(5));
                        check("rds_p5", rd_cnt, 8);
                        check("lat_p5", cyc - first_rd, 11);
                    end
                    if (beats == stall_pix) begin
                        check("stall_taps", taps(), exp_taps(stall_pix));
                        check("stall_rd", rd_in_stall, 1'b0);
                        check("stall_len", stall, 5);
                        resume_at = cyc + 1;
                    end
                    beats++;
                    rd_cnt = 0;
                end
            end
            if (dones > 0 && !busy) fin = 1'b1;
        end
        start = 1'b0;
        out_ready = 1'b1;
        check("frame_end", fin, 1'b1);
        check("beats", beats, 16);
        check("dones", dones, 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, {busy, done, mem_rd, out_valid, out_last}, 5'b0);
        check({tag, "_addr"}, mem_addr, 16'h0);
        check({tag, "_taps"}, taps(), 64'h0);
        check({tag, "_data"}, out_data, 8'h0);
    endtask

    initial begin
        int beats, cyc;
        bit found, stray;
        for (int k = 0; k < 16; k++) mem[k] = 8'(k);

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        stray = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (mem_rd || busy) stray = 1'b1;
        end
        check("idle_after_reset", stray, 1'b0);

        run_frame(-1, 1'b0);
        repeat (2) @(negedge clk);
        run_frame(6, 1'b1);
        repeat (2) @(negedge clk);

        // Abort in the middle of pixel 6's fetch.
        beats = 0; cyc = 0; found = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!found && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (beats == 6 && mem_rd) found = 1'b1;
            else if (out_valid) beats++;
        end
        check("reach_p6_fetch", found, 1'b1);
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (mem_rd || busy) stray = 1'b1;
        end
        check("no_rd_after_rst", stray, 1'b0);
        run_frame(-1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
